// File: rtl/fsp_result_collector.sv
// Round-robin collector: takes results from N_SUMMER row summers into a first-word-fall-through output FIFO.
// Latency: done sampled -> sum_ack on the next edge -> FIFO write on the edge after (one result per 2 cycles).
// Backpressure: a full FIFO holds the arbiter in SCAN, and the summers hold done until they are acked.
`timescale 1ns/1ps

module fsp_result_collector #(
  parameter int FP_SIZE    = 32,
  parameter int N_SUMMER   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DELAY      = 1
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [N_SUMMER-1:0]           done,
  input  logic [N_SUMMER*FP_SIZE-1:0]   grn_result,
  input  logic [N_SUMMER*FP_SIZE-1:0]   red_result,
  output logic [N_SUMMER-1:0]           sum_ack,
  input  logic                          xof,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [$clog2(N_SUMMER)-1:0]   out_idx,
  output logic [FP_SIZE-1:0]            out_grn,
  output logic [FP_SIZE-1:0]            out_red,
  output logic                          frame_flushed,
  output logic                          protocol_err,
  output logic [15:0]                   result_count
);

  localparam int IW = $clog2(N_SUMMER);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // DELAY only applies to behavioural models. The registers here use zero delay, so the
  // parameter only takes part in the elaboration-time sanity checks below.
  if (DELAY < 0 || N_SUMMER < 2 || (N_SUMMER & (N_SUMMER - 1)) != 0 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_chk
    $error("fsp_result_collector: illegal parameter combination");
  end

  typedef enum logic {SCAN = 1'b0, CAPTURE = 1'b1} state_t;

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     cand;
  logic              found;
  logic              flush_pending;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              wr_en;
  logic              rd_en;
  logic              idle;
  logic              pend;

  logic [IW-1:0]      mem_idx [FIFO_DEPTH];
  logic [FP_SIZE-1:0] mem_grn [FIFO_DEPTH];
  logic [FP_SIZE-1:0] mem_red [FIFO_DEPTH];

  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign wr_en     = (state == CAPTURE) && done[sel];
  assign out_valid = (fifo_count != '0);
  assign rd_en     = out_valid && out_ready;
  // Drained means no capture in flight, no summer holding a result, and nothing left to deliver
  assign idle      = (state == SCAN) && (done == '0) && (fifo_count == '0);
  // An xof that arrives while a flush is already pending folds into the pending one
  assign pend      = flush_pending | xof;

  // Head entry is gated by out_valid so the outputs read zero whenever the FIFO is empty
  assign out_idx = out_valid ? mem_idx[rd_ptr] : '0;
  assign out_grn = out_valid ? mem_grn[rd_ptr] : '0;
  assign out_red = out_valid ? mem_red[rd_ptr] : '0;

  // First requesting summer at or above rr_ptr, wrapping around (N_SUMMER is a power of 2)
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_SUMMER; i++) begin
      cand = rr_ptr + IW'(i);
      if (!found && done[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Arbiter FSM, FIFO pointers, counters and flush tracking
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= SCAN;
      rr_ptr        <= '0;
      sel           <= '0;
      sum_ack       <= '0;
      result_count  <= '0;
      protocol_err  <= 1'b0;
      flush_pending <= 1'b0;
      frame_flushed <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
    end else begin
      sum_ack <= '0;
      case (state)
        SCAN: begin
          if (found && !fifo_full) begin
            sel     <= pick;
            sum_ack <= N_SUMMER'(1) << pick;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          state <= SCAN;
          if (done[sel]) begin
            rr_ptr       <= sel + IW'(1);
            result_count <= result_count + 16'd1;
          end else begin
            // The summer dropped done before it was acked: its result is lost
            protocol_err <= 1'b1;
          end
        end
        default: state <= SCAN;
      endcase

      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(wr_en) - CW'(rd_en);

      frame_flushed <= pend && idle;
      flush_pending <= pend && !idle;
    end
  end

  // FIFO storage needs no reset: the read side is masked until an entry is written
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_idx[wr_ptr] <= sel;
      mem_grn[wr_ptr] <= grn_result[sel*FP_SIZE +: FP_SIZE];
      mem_red[wr_ptr] <= red_result[sel*FP_SIZE +: FP_SIZE];
    end
  end

endmodule
